// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types for the shift/rotate register controller: command modes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Command/data bundle between a producer (master) and the shift register controller (slave).
interface shift_reg_ctrl_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);

  logic [WIDTH-1:0] d;
  logic             load;
  logic             start;
  mode_e            mode;
  logic [CNT_W-1:0] amount;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output d, load, start, mode, amount, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  d, load, start, mode, amount, sin,
    output q, sout, busy, done
  );

endinterface

// File: rtl/shift_reg_ctrl_step.sv
// Combinational single-bit step: next register value and the bit that leaves the word.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_e            i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_out
);

  // Shifts pull in sin; rotates recirculate the bit that falls off the end.
  always_comb begin
    o_q   = i_q;
    o_out = 1'b0;
    case (i_mode)
      SHL: begin
        o_q   = {i_q[WIDTH-2:0], i_sin};
        o_out = i_q[WIDTH-1];
      end
      SHR: begin
        o_q   = {i_sin, i_q[WIDTH-1:1]};
        o_out = i_q[0];
      end
      ROL: begin
        o_q   = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_out = i_q[WIDTH-1];
      end
      ROR: begin
        o_q   = {i_q[0], i_q[WIDTH-1:1]};
        o_out = i_q[0];
      end
      default: begin
        o_q   = i_q;
        o_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Parallel-load register that shifts or rotates a commanded number of single-bit steps,
// one per clock, reporting busy while running and a one-cycle done pulse at the end.
module shift_reg_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  shift_reg_ctrl_if.slave  bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_remaining;
  mode_e            r_mode;

  state_e           w_nextState;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextSout;
  logic             w_nextBusy;
  logic             w_nextDone;
  logic [CNT_W-1:0] w_nextRemaining;
  mode_e            w_nextMode;
  logic [WIDTH-1:0] w_stepQ;
  logic             w_stepOut;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_mode (r_mode),
    .i_sin  (bus.sin),
    .o_q    (w_stepQ),
    .o_out  (w_stepOut)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_sout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_mode      <= SHL;
    end else begin
      r_state     <= w_nextState;
      r_q         <= w_nextQ;
      r_sout      <= w_nextSout;
      r_busy      <= w_nextBusy;
      r_done      <= w_nextDone;
      r_remaining <= w_nextRemaining;
      r_mode      <= w_nextMode;
    end
  end

  // Requests are only looked at in IDLE; while shifting, the latched mode drives every step.
  always_comb begin
    w_nextState     = r_state;
    w_nextQ         = r_q;
    w_nextSout      = r_sout;
    w_nextDone      = 1'b0;
    w_nextRemaining = r_remaining;
    w_nextMode      = r_mode;
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_nextQ = bus.d;
        end else if (bus.start) begin
          if (bus.amount != '0) begin
            w_nextMode      = bus.mode;
            w_nextRemaining = bus.amount;
            w_nextState     = SHIFT;
          end else begin
            w_nextDone = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_nextQ         = w_stepQ;
        w_nextSout      = w_stepOut;
        w_nextRemaining = r_remaining - CNT_W'(1);
        if (r_remaining == CNT_W'(1)) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    w_nextBusy = (w_nextState == SHIFT);
  end

  assign bus.q    = r_q;
  assign bus.sout = r_sout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
